// File: rtl/lifm_partition_feeder.sv
// Column FIFO feeding LIFM partitions of R columns to the downstream redundancy stage.
// Optional macro LIFM_ZERO_SKIP_EN drops all-zero columns at the FIFO input.
module lifm_partition_feeder #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int RSIZ_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH-1:0]            in_kidx,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] in_column,
  input  logic                             flush,
  input  logic [RSIZ_WIDTH-1:0]            rsiz,
  input  logic                             done_in,
  output logic                             enable_out,
  output logic [WORD_WIDTH-1:0]            kidx,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column,
  output logic                             part_last,
  output logic [15:0]                      part_cnt
);

  localparam int COL_W = WORD_WIDTH * STEP_RANGE;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CMP_W = (RSIZ_WIDTH + 1 > CW) ? RSIZ_WIDTH + 1 : CW;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] kidx;
    logic [COL_W-1:0]      col;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  entry_t [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, remaining;
  state_t                  state, state_nxt;

  logic             accept, store, pop, start, last_pop;
  logic [CMP_W-1:0] r_eff, cnt_x, n_entry;

  assign in_ready = (count != CW'(FIFO_DEPTH));
  assign accept   = in_valid & in_ready;

`ifdef LIFM_ZERO_SKIP_EN
  assign store = accept & (|in_column);
`else
  assign store = accept;
`endif

  assign pop      = (state == ISSUE);
  assign last_pop = pop & (remaining == CW'(1));

  // Partition length is fixed at ISSUE entry: min(R, occupancy); a flush may start it short.
  always_comb begin
    r_eff   = (CMP_W'(rsiz) < CMP_W'(2)) ? CMP_W'(2) : CMP_W'(rsiz);
    cnt_x   = CMP_W'(count);
    n_entry = (cnt_x < r_eff) ? cnt_x : r_eff;
    start   = (cnt_x >= r_eff) || (flush && (count != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    enable_out  = 1'b0;
    part_last   = 1'b0;
    kidx        = '0;
    lifm_column = '0;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        enable_out  = 1'b1;
        kidx        = mem[rd_ptr].kidx;
        lifm_column = mem[rd_ptr].col;
        if (last_pop) begin
          part_last = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (done_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      part_cnt  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (state == IDLE && start) remaining <= CW'(n_entry);
      else if (pop)               remaining <= remaining - CW'(1);
      if (last_pop) part_cnt <= part_cnt + 16'd1;
    end
  end

  // Storage is not reset: entries are only visible through rd_ptr while issuing.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= '{kidx: in_kidx, col: in_column};
  end

endmodule
